seq_mult_16b: RTL and testbench
===============================

// Module: seq_mult_16b
// PURPOSE
//  16x16 unsigned shift-add multiplier built on the cla_16b carry-lookahead adder.
//  Sits directly downstream of cla_16b: one cla_16b instance adds the multiplicand
//  into the upper partial-product half each iteration. Feeds the ALU result mux
//  with a registered 32-bit product.
// PARAMETERS
//  WIDTH    16  operand width; only 16 is supported (adder instance is fixed at 16b)
//  CNT_W    5   iteration counter width; must hold values 0..WIDTH
// PORTS
//  clk      in   1   rising-edge clock
//  reset    in   1   asynchronous, active-high reset
//  start    in   1   request; sampled on rising clk, accepted in IDLE or DONE only
//  mcand    in   16  multiplicand, captured when start is accepted
//  mplier   in   16  multiplier, captured when start is accepted
//  busy     out  1   high while in CALC
//  done     out  1   one-cycle pulse; product valid from this cycle
//  product  out  32  {P_hi,P_lo}; valid and held from done until the next accepted start
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, count=0, P_hi=0, P_lo=0, M=0,
//   busy=0, done=0, product=0. Reset mid-CALC aborts; no done is issued.
//  States: IDLE, CALC, DONE.
//   IDLE: start=1 -> M<=mcand, P_hi<=0, P_lo<=mplier, count<=0, go CALC.
//   CALC: one iteration per cycle, exactly WIDTH (16) cycles.
//    P_lo[0]=1: {c,s}=cla_16b(P_hi,M,c_in=0); {P_hi,P_lo}<={c,s,P_lo[15:1]}.
//    P_lo[0]=0: {P_hi,P_lo}<={1'b0,P_hi,P_lo[15:1]}.
//    count<=count+1; when count==15 (16th iteration), go DONE.
//   DONE: done=1 for this cycle only. start=1 here is accepted exactly as
//    in IDLE (back-to-back, go CALC); else go IDLE.
//  Latency: start accepted at edge 0 -> CALC on edges 1..16 -> done high in the
//   cycle after edge 16. Result is ready 17 cycles after acceptance.
//  busy=1 iff state==CALC; done=1 iff state==DONE (both decoded from state regs).
//  start during CALC: ignored; operands are not re-captured; no queuing.
//  Operand changes after acceptance have no effect on the running operation.
//  product = {P_hi,P_lo} continuously. It is meaningful only from done until the
//   next accepted start; in IDLE it holds the last result.
//  Arithmetic: unsigned only. The adder carry-out is the bit shifted into P_hi[15],
//   so no overflow is possible: max 0xFFFF*0xFFFF = 0xFFFE0001 fits in 32b.
// TESTING
//  T1 mcand=0x0003, mplier=0x0005, start pulse -> busy 16 cycles, done pulse,
//     product=0x0000000F.
//  T2 mcand=0xFFFF, mplier=0xFFFF -> product=0xFFFE0001 (exercises carry-out path).
//  T3 mcand=0x0000, mplier=0x1234, and mcand=0x1234, mplier=0x0000 -> product=0,
//     done still at cycle 17.
//  T4 start=1 held during CALC with new operands (0x0002,0x0002) -> ignored,
//     first result 0x0000000F; start in DONE cycle -> second op gives 0x00000004.
//  T5 reset asserted asynchronously at CALC iteration 8 -> busy, done, product go
//     0 immediately; done never pulses; next op 0x00FF*0x0101 = 0x0000FFFF.
//  T6 random 1000 operand pairs vs a*b reference; check done exactly 17 cycles after
//     acceptance and product stable until the next start.

Source files
------------

// File: rtl/seq_mult_16b.sv
// seq_mult_16b: 16x16 unsigned shift-add multiplier with a registered 32-bit product.
// One cla_16b instance adds the multiplicand into the upper partial-product half.
// One iteration per clock; the result appears 17 cycles after start is accepted.

// cla_16b: 16-bit carry-lookahead adder (four 4-bit groups with group lookahead)
module cla_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  cg;

    // Generate/propagate, group carries, then expanded in-group carries
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        gg    = '0;
        gp    = '0;
        cg    = '0;
        cg[0] = c_in;
        for (int unsigned k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            cg[k+1] = gg[k] | (gp[k] & cg[k]);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
        c[16] = cg[4];
        sum   = p ^ c[15:0];
        c_out = c[16];
    end

endmodule

// Sequential multiplier; WIDTH must stay 16 because the adder instance is fixed at 16 bits
module seq_mult_16b #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;
    logic [WIDTH-1:0]   m_q, m_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_co;

    cla_16b u_add (
        .a     (p_hi_q),
        .b     (m_q),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_co)
    );

    // Next-state: capture operands on accepted start, one shift-add step per CALC cycle
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        m_d     = m_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = mcand;
                    p_hi_d  = '0;
                    p_lo_d  = mplier;
                    count_d = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // Adder carry-out becomes the new MSB, so the shift never loses a bit
                if (p_lo_q[0]) begin
                    {p_hi_d, p_lo_d} = {add_co, add_sum, p_lo_q[WIDTH-1:1]};
                end else begin
                    {p_hi_d, p_lo_d} = {1'b0, p_hi_q, p_lo_q[WIDTH-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            m_q     <= m_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = {p_hi_q, p_lo_q};

endmodule

// File: tb/tb_seq_mult_16b.sv
// Bench for seq_mult_16b: a cycle-count model of the operation plus directed literal checks.
module tb_seq_mult_16b;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks   = 0;
    int failures = 0;

    localparam int K_IDLE = 1000;

    // Model: k = clock edges since the accepting edge (K_IDLE when nothing ran)
    int          mdl_k    = K_IDLE;
    logic [31:0] mdl_pend = '0;
    logic [31:0] mdl_last = '0;

    seq_mult_16b #(.WIDTH(16), .CNT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: accept in idle/done, busy for 16 cycles, result at k==16
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_k    = K_IDLE;
            mdl_last = '0;
        end else begin
            if (start && mdl_k >= 16) begin
                mdl_k    = 0;
                mdl_pend = 32'(mcand) * 32'(mplier);
            end else if (mdl_k < K_IDLE) begin
                mdl_k++;
            end
            if (mdl_k == 16) mdl_last = mdl_pend;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(mdl_k <= 15));
        check("done", 32'(done), 32'(mdl_k == 16));
        if (mdl_k >= 16) check("product", product, mdl_last);
    end

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        check(name, 32'(n), 32'd17);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        #23;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prod", product, 32'd0);
        reset = 1'b0;

        // T1
        start_op(16'h0003, 16'h0005);
        wait_done("t1_lat");
        check("t1_prod", product, 32'h0000000F);
        check("model_pin", mdl_last, 32'h0000000F);

        // T2
        start_op(16'hFFFF, 16'hFFFF);
        wait_done("t2_lat");
        check("t2_prod", product, 32'hFFFE0001);

        // T3
        start_op(16'h0000, 16'h1234);
        wait_done("t3a_lat");
        check("t3a_prod", product, 32'h0);
        start_op(16'h1234, 16'h0000);
        wait_done("t3b_lat");
        check("t3b_prod", product, 32'h0);

        // T4: start held through CALC with new operands, accepted again in DONE
        @(posedge clk); #1;
        mcand = 16'h0003; mplier = 16'h0005; start = 1'b1;
        @(posedge clk); #1;
        mcand = 16'h0002; mplier = 16'h0002;
        wait_done("t4a_lat");
        check("t4a_prod", product, 32'h0000000F);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t4b_lat");
        check("t4b_prod", product, 32'h00000004);

        // T5: asynchronous reset mid-operation
        start_op(16'h1234, 16'h5678);
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_prod", product, 32'd0);
        @(negedge clk); #2;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        start_op(16'h00FF, 16'h0101);
        wait_done("t5_lat");
        check("t5_next", product, 32'h0000FFFF);

        // T6: random operands, operands scrambled after acceptance
        for (int unsigned i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 50 == 0) ra = 16'hFFFF;
            start_op(ra, rb);
            mcand  = 16'($urandom);
            mplier = 16'($urandom);
            wait_done("t6_lat");
            check("t6_prod", product, 32'(ra) * 32'(rb));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
